// File: rtl/ucsbece154a_lsu.sv
// Load/store unit: one req/ack memory transaction per accepted start. Store data is
// steered onto byte lanes and load data is sign- or zero-extended for writeback.
module ucsbece154a_lsu #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] cnt;

    function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        logic al;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !we;
            default:                ok = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   al = !lo[0];
            2'b10:   al = (lo == 2'b00);
            default: al = 1'b1;
        endcase
        return ok && al;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] w);
        logic [15:0]        h;
        logic [7:0]         b;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        h  = lo[1] ? w[31:16] : w[15:0];
        b  = lo[0] ? h[15:8] : h[7:0];
        sb = b;
        sh = h;
        case (f3)
            3'b000:  r = sb;
            3'b001:  r = sh;
            3'b010:  r = w;
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic start_ok;
    assign start_ok = legal(we_i, funct3_i, addr_i[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            lo_q        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (mem_ack_i) begin
                        state       <= RESP;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        err_o       <= 1'b0;
                        rdata_o     <= we_q ? 32'b0 : load_extend(f3_q, lo_q, mem_rdata_i);
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '0;
                        mem_wdata_o <= '0;
                    end else if (WAIT_LIMIT != 0 && cnt == WAIT_LIMIT - 1) begin
                        state       <= RESP;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        err_o       <= 1'b1;
                        rdata_o     <= '0;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '0;
                        mem_wdata_o <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept a new start; RESP retires its done pulse here
                    done_o <= 1'b0;
                    state  <= IDLE;
                    if (start_i) begin
                        if (start_ok) begin
                            state       <= REQ;
                            busy_o      <= 1'b1;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= we_i;
                            mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem_be_o    <= we_i ? store_lanes(funct3_i, addr_i[1:0]) : 4'b1111;
                            mem_wdata_o <= we_i ? store_data(funct3_i, wdata_i) : 32'b0;
                            we_q        <= we_i;
                            f3_q        <= funct3_i;
                            lo_q        <= addr_i[1:0];
                            cnt         <= '0;
                        end else begin
                            state   <= RESP;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154a_lsu.sv
// Directed bench for ucsbece154a_lsu with a result scoreboard and a simple memory responder.
module tb_ucsbece154a_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    ucsbece154a_lsu #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pops = 0;
    int   done_seen = 0;

    always @(negedge clk) if (done_o) done_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        check({tag, "_sb_pending"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            n_pops++;
            check({tag, "_rdata"}, rdata_o, e.rd);
            check({tag, "_err"}, 32'(err_o), 32'(e.err));
        end
    endtask

    task automatic drive_start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        start_i  = 1'b1;
        we_i     = we;
        funct3_i = f3;
        addr_i   = a;
        wdata_i  = wd;
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int dly,
                          input logic [31:0] mrd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        drive_start(we, f3, a, wd);
        sb_push(erd, 1'b0);
        tick();
        start_i = 1'b0;
        check({tag, "_req"}, 32'(mem_req_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_we"}, 32'(mem_we_o), 32'(we));
        check({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
        check({tag, "_be"}, 32'(mem_be_o), 32'(ebe));
        check({tag, "_wdata"}, mem_wdata_o, ewd);
        for (int i = 0; i < dly; i++) begin
            tick();
            check({tag, "_req_hold"}, 32'(mem_req_o), 32'd1);
            check({tag, "_addr_hold"}, mem_addr_o, {a[31:2], 2'b00});
            check({tag, "_be_hold"}, 32'(mem_be_o), 32'(ebe));
            check({tag, "_no_early_done"}, 32'(done_o), 32'd0);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = mrd;
        tick();
        mem_ack_i = 1'b0;
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
        check({tag, "_busy_resp"}, 32'(busy_o), 32'd0);
        sb_pop(tag);
        tick();
        check({tag, "_done_once"}, 32'(done_o), 32'd0);
        check({tag, "_rdata_hold"}, rdata_o, erd);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a);
        drive_start(we, f3, a, 32'h1234_5678);
        sb_push(32'h0, 1'b1);
        tick();
        start_i = 1'b0;
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_noreq"}, 32'(mem_req_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        sb_pop(tag);
        tick();
        check({tag, "_done_once"}, 32'(done_o), 32'd0);
        check({tag, "_noreq2"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);

        // ack while idle must not produce anything
        mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;
        check("idle_ack_done", 32'(done_o), 32'd0);
        check("idle_ack_busy", 32'(busy_o), 32'd0);

        do_txn("lw",  1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        do_txn("lb",  1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'hFFFFFF80);
        do_txn("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF1234, 4'b1111, 32'h0, 32'h00000080);
        do_txn("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'h000080FF);
        do_txn("lh_hi", 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'hFFFF80FF);
        do_txn("lh_lo", 1'b0, 3'b001, 32'h200, 32'h0, 0, 32'h80FF9234, 4'b1111, 32'h0, 32'hFFFF9234);
        do_txn("lb0", 1'b0, 3'b000, 32'h200, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'h00000034);
        do_txn("sb",  1'b1, 3'b000, 32'h11, 32'h000000A5, 0, 32'hFFFFFFFF, 4'b0010, 32'hA5A5A5A5, 32'h0);
        do_txn("sh",  1'b1, 3'b001, 32'h22, 32'h0000BEEF, 2, 32'hFFFFFFFF, 4'b1100, 32'hBEEFBEEF, 32'h0);
        do_txn("sh_lo", 1'b1, 3'b001, 32'h20, 32'h00001357, 0, 32'h0, 4'b0011, 32'h13571357, 32'h0);
        do_txn("sw",  1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 1, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);

        do_err("lw_mis", 1'b0, 3'b010, 32'h102);
        do_err("ld_f3_011", 1'b0, 3'b011, 32'h100);
        do_err("st_f3_100", 1'b1, 3'b100, 32'h100);
        do_err("lh_mis", 1'b0, 3'b001, 32'h201);
        do_err("sw_mis", 1'b1, 3'b010, 32'h101);

        // timeout: no ack, request held for exactly WAIT_LIMIT cycles
        drive_start(1'b0, 3'b010, 32'h300, 32'h0);
        sb_push(32'h0, 1'b1);
        tick();
        start_i = 1'b0;
        n = 0;
        while (mem_req_o && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_done", 32'(done_o), 32'd1);
        sb_pop("to");
        tick();
        check("to_done_once", 32'(done_o), 32'd0);

        // leave a nonzero rdata behind, then reset in the middle of a request
        do_txn("pre_rst", 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h55AA55AA, 4'b1111, 32'h0, 32'h55AA55AA);
        drive_start(1'b0, 3'b010, 32'h500, 32'h0);
        tick();
        start_i = 1'b0;
        check("mid_req", 32'(mem_req_o), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_req", 32'(mem_req_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_rdata", rdata_o, 32'd0);
        check("mid_rst_addr", mem_addr_o, 32'd0);
        check("mid_rst_be", 32'(mem_be_o), 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_ack_done", 32'(done_o), 32'd0);
        end
        mem_ack_i = 1'b0;

        // back-to-back: new start presented during the RESP cycle
        drive_start(1'b1, 3'b010, 32'h40, 32'h11223344);
        sb_push(32'h0, 1'b0);
        tick();
        start_i = 1'b0;
        check("b2b_sw_req", 32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("b2b_sw_done", 32'(done_o), 32'd1);
        sb_pop("b2b_sw");
        drive_start(1'b0, 3'b010, 32'h48, 32'h0);
        sb_push(32'hA1B2C3D4, 1'b0);
        tick();
        start_i = 1'b0;
        check("b2b_lw_done_low", 32'(done_o), 32'd0);
        check("b2b_lw_req", 32'(mem_req_o), 32'd1);
        check("b2b_lw_we", 32'(mem_we_o), 32'd0);
        check("b2b_lw_addr", mem_addr_o, 32'h48);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA1B2C3D4;
        tick();
        mem_ack_i = 1'b0;
        check("b2b_lw_done", 32'(done_o), 32'd1);
        sb_pop("b2b_lw");
        tick();
        check("b2b_lw_done_once", 32'(done_o), 32'd0);
        tick();

        check("sb_drained", 32'(q.size()), 32'd0);
        check("done_pulse_count", 32'(done_seen), 32'(n_pops));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
